// File: rtl/timer_counter_gen2_pkg.sv
// Shared timer constants: counting modes, flag_clr bit indices and
// default widths for the gen2 timer counter and its prescaler.
package timer_counter_gen2_pkg;

  localparam int CNT_W_DEF = 64;
  localparam int DIV_W_DEF = 8;

  localparam logic MODE_FREERUN = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam int FLAG_MATCH = 0;
  localparam int FLAG_OVF   = 1;

endpackage

// File: rtl/timer_counter_gen2_if.sv
// Control/status bundle between the APB register block, the timer core
// and the interrupt logic. master drives control, slave is the core.
interface timer_counter_gen2_if
  import timer_counter_gen2_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
);
  localparam int NWORD = CNT_W / 32;

  logic             count_en;
  logic             div_en;
  logic [DIV_W-1:0] div_val;
  logic             mode;
  logic             halt_req;
  logic             dbg_mode;
  logic [31:0]      wdata;
  logic [3:0]       pstrb;
  logic [NWORD-1:0] wr_sel;
  logic [CNT_W-1:0] cmp_val;
  logic [1:0]       flag_clr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_tick;
  logic             match_flag;
  logic             ovf_flag;
  logic             halt_ack;

  modport master (
    output count_en, div_en, div_val, mode,
    output halt_req, dbg_mode,
    output wdata, pstrb, wr_sel,
    output cmp_val, flag_clr,
    input  cnt, cnt_tick, match_flag,
    input  ovf_flag, halt_ack
  );

  modport slave (
    input  count_en, div_en, div_val, mode,
    input  halt_req, dbg_mode,
    input  wdata, pstrb, wr_sel,
    input  cmp_val, flag_clr,
    output cnt, cnt_tick, match_flag,
    output ovf_flag, halt_ack
  );

endinterface

// File: rtl/timer_counter_gen2_prescaler.sv
// Linear prescaler: clk, rst_n, count_en, div_en, div_val, halted,
// restart in; tick out (combinational, one per div_val+1 active cycles).
module timer_prescaler
  import timer_counter_gen2_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_en,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             halted,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             active;
  logic             reached;

  assign active  = count_en & ~halted;
  // >= so a lowered div_val fires on the next active cycle
  assign reached = div_cnt_q >= div_val;
  assign tick    = active & (~div_en | reached);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (restart || !count_en || !div_en) begin
      div_cnt_d = '0;
    end else if (!halted) begin
      div_cnt_d = reached ? '0 : div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/timer_counter_gen2.sv
// Timer counter core: sys_clk, sys_rst_n and a slave bundle carrying
// control, byte-strobed word writes, compare value and sticky flags.
module timer_counter_gen2
  import timer_counter_gen2_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  timer_counter_gen2_if.slave  tif
);

  localparam int NWORD = CNT_W / 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_val;
  logic             cnt_tick_q, cnt_tick_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;

  logic halted;
  logic tick;
  logic wr;
  logic cnt_upd;
  logic at_cmp;
  logic at_max;
  logic reload;

  assign halted  = tif.halt_req & tif.dbg_mode;
  assign wr      = |tif.wr_sel;
  assign cnt_upd = tick & ~wr;
  assign at_cmp  = cnt_q == tif.cmp_val;
  assign at_max  = &cnt_q;
  assign reload  = tif.mode == MODE_RELOAD;

  timer_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .count_en (tif.count_en),
    .div_en   (tif.div_en),
    .div_val  (tif.div_val),
    .halted   (halted),
    .restart  (wr),
    .tick     (tick)
  );

  // every selected word gets the same strobed bytes
  for (genvar k = 0; k < NWORD; k++) begin : g_word
    for (genvar b = 0; b < 4; b++) begin : g_byte
      localparam int LSB = 32 * k + 8 * b;
      assign wr_val[LSB +: 8] =
        (tif.wr_sel[k] & tif.pstrb[b]) ?
        tif.wdata[8*b +: 8] : cnt_q[LSB +: 8];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (wr) begin
      cnt_d = wr_val;
    end else if (cnt_upd) begin
      cnt_d = (reload && at_cmp) ? '0 : cnt_q + CNT_W'(1);
    end
    cnt_tick_d = cnt_upd;
    // a new set beats a same-cycle clear
    match_d = (cnt_upd & at_cmp)
            | (match_q & ~tif.flag_clr[FLAG_MATCH]);
    ovf_d   = (cnt_upd & at_max & ~reload)
            | (ovf_q & ~tif.flag_clr[FLAG_OVF]);
    ack_d   = halted;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      cnt_tick_q <= 1'b0;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cnt_tick_q <= cnt_tick_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
    end
  end

  assign tif.cnt        = cnt_q;
  assign tif.cnt_tick   = cnt_tick_q;
  assign tif.match_flag = match_q;
  assign tif.ovf_flag   = ovf_q;
  assign tif.halt_ack   = ack_q;

endmodule

// File: tb/tb_timer_counter_gen2.sv
// Self-checking bench for timer_counter_gen2: cycle model feeding an
// expected-output queue plus directed checks from the feature scenarios.
module tb_timer_counter_gen2;
  import timer_counter_gen2_pkg::*;

  localparam int CW = 64;
  localparam int DW = 8;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          tick;
    logic          match;
    logic          ovf;
    logic          ack;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [CW-1:0] m_cnt;
  logic [DW-1:0] m_div;
  logic m_tick, m_match, m_ovf, m_ack;

  timer_counter_gen2_if #(.CNT_W(CW), .DIV_W(DW)) tif ();

  timer_counter_gen2 #(.CNT_W(CW), .DIV_W(DW)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .tif       (tif)
  );

  always #5 clk = ~clk;

  function automatic exp_t dut_out();
    return {tif.cnt, tif.cnt_tick, tif.match_flag,
            tif.ovf_flag, tif.halt_ack};
  endfunction

  task automatic idle();
    tif.count_en = 0; tif.div_en = 0; tif.div_val = '0;
    tif.mode = MODE_FREERUN; tif.halt_req = 0; tif.dbg_mode = 0;
    tif.wdata = '0; tif.pstrb = '0; tif.wr_sel = '0;
    tif.cmp_val = 64'h1234_5678_0000_0000; tif.flag_clr = '0;
  endtask

  task automatic model_reset();
    m_cnt = '0; m_div = '0;
    m_tick = 0; m_match = 0; m_ovf = 0; m_ack = 0;
    sb.delete();
  endtask

  // predict the next registered outputs, queue them, clock the DUT
  task automatic advance();
    exp_t e;
    logic hl, wr, tk, upd;
    logic [CW-1:0] nc;
    hl = tif.halt_req && tif.dbg_mode;
    wr = tif.wr_sel != 0;
    tk = tif.count_en && !hl && (!tif.div_en || m_div >= tif.div_val);
    upd = tk && !wr;
    nc = m_cnt;
    if (wr) begin
      for (int k = 0; k < 2; k++)
        for (int b = 0; b < 4; b++)
          if (tif.wr_sel[k] && tif.pstrb[b])
            nc[32*k+8*b +: 8] = tif.wdata[8*b +: 8];
    end else if (upd) begin
      nc = (tif.mode && m_cnt == tif.cmp_val) ? '0 : m_cnt + 64'd1;
    end
    m_match = (upd && m_cnt == tif.cmp_val) || (m_match && !tif.flag_clr[0]);
    m_ovf = (upd && !tif.mode && m_cnt == '1) || (m_ovf && !tif.flag_clr[1]);
    m_tick = upd;
    m_ack = hl;
    if (wr || !tif.count_en || !tif.div_en) m_div = '0;
    else if (!hl) m_div = tk ? '0 : m_div + 8'd1;
    m_cnt = nc;
    e = {m_cnt, m_tick, m_match, m_ovf, m_ack};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // clears cnt, flags and prescaler; its prediction is discarded
  task automatic setup();
    exp_t e;
    idle();
    tif.wr_sel = 2'b11; tif.pstrb = 4'hF; tif.flag_clr = 2'b11;
    advance();
    e = sb.pop_front();
    tif.wr_sel = '0; tif.pstrb = '0; tif.flag_clr = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_out() !== '0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", dut_out());
    end
    @(posedge clk); #1;
    checks++;
    if (dut_out() !== '0) begin
      errors++; $display("FAIL reset_hold got=%h exp=0", dut_out());
    end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_count();
    exp_t e; int nt = 0;
    tif.count_en = 1;
    for (int i = 0; i < 5; i++) begin
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e) begin
        errors++; $display("FAIL count_sb[%0d] got=%h exp=%h", i, dut_out(), e);
      end
      if (tif.cnt_tick === 1'b1) nt++;
    end
    checks++;
    if (tif.cnt !== 64'd5) begin
      errors++; $display("FAIL count_val got=%0d exp=5", tif.cnt);
    end
    checks++;
    if (nt != 5) begin
      errors++; $display("FAIL count_ticks got=%0d exp=5", nt);
    end
    checks++;
    if ({tif.match_flag, tif.ovf_flag} !== 2'b00) begin
      errors++; $display("FAIL count_flags got=%b exp=00",
                         {tif.match_flag, tif.ovf_flag});
    end
    tif.count_en = 0;
  endtask

  task automatic test_prescaler();
    exp_t e; int tpos[$];
    setup();
    tif.div_en = 1; tif.div_val = 8'd3; tif.count_en = 1;
    for (int i = 0; i < 15; i++) begin
      if (i == 14) tif.div_val = 8'd0;
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e) begin
        errors++; $display("FAIL presc_sb[%0d] got=%h exp=%h", i, dut_out(), e);
      end
      if (tif.cnt_tick === 1'b1) tpos.push_back(i);
      if (i == 11) begin
        checks++;
        if (tif.cnt !== 64'd3) begin
          errors++; $display("FAIL presc_cnt12 got=%0d exp=3", tif.cnt);
        end
      end
    end
    checks++;
    if (tpos.size() != 4 || tpos[0] != 3 || tpos[1] != 7 ||
        tpos[2] != 11 || tpos[3] != 14) begin
      errors++; $display("FAIL presc_spacing got=%p exp='{3,7,11,14}", tpos);
    end
    checks++;
    if (tif.cnt !== 64'd4) begin
      errors++; $display("FAIL presc_lower got=%0d exp=4", tif.cnt);
    end
    idle();
  endtask

  task automatic test_write();
    exp_t e;
    logic [CW-1:0] base;
    base = 64'h00BB00DD_00000000;
    setup();
    tif.div_en = 1; tif.div_val = 8'd3; tif.count_en = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        tif.wr_sel = 2'b10; tif.pstrb = 4'b0101; tif.wdata = 32'hAABBCCDD;
      end else begin
        tif.wr_sel = '0;
      end
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e) begin
        errors++; $display("FAIL write_sb[%0d] got=%h exp=%h", i, dut_out(), e);
      end
      if (i >= 3) begin
        checks++;
        if (tif.cnt !== ((i == 7) ? base + 64'd1 : base) ||
            tif.cnt_tick !== (i == 7)) begin
          errors++; $display("FAIL write_cnt[%0d] got=%h/%b exp=%h/%b", i,
            tif.cnt, tif.cnt_tick, (i == 7) ? base + 64'd1 : base, i == 7);
        end
      end
    end
    idle();
  endtask

  task automatic test_reload();
    exp_t e;
    logic [CW-1:0] seq [6];
    seq = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd1};
    setup();
    tif.mode = MODE_RELOAD; tif.cmp_val = 64'd4; tif.count_en = 1;
    for (int i = 0; i < 10; i++) begin
      tif.flag_clr = (i == 6 || i == 9) ? 2'b01 : 2'b00;
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e) begin
        errors++; $display("FAIL reload_sb[%0d] got=%h exp=%h", i, dut_out(), e);
      end
      if (i < 6) begin
        checks++;
        if (tif.cnt !== seq[i] || tif.match_flag !== (i >= 4)) begin
          errors++; $display("FAIL reload_seq[%0d] got=%0d/%b exp=%0d/%b", i,
            tif.cnt, tif.match_flag, seq[i], i >= 4);
        end
      end
      if (i == 6) begin
        checks++;
        if (tif.match_flag !== 1'b0) begin
          errors++; $display("FAIL reload_clr got=%b exp=0", tif.match_flag);
        end
      end
    end
    checks++;
    if (tif.match_flag !== 1'b1 || tif.cnt !== 64'd0) begin
      errors++; $display("FAIL reload_setwins got=%b/%0d exp=1/0",
                         tif.match_flag, tif.cnt);
    end
    tif.cmp_val = '0; tif.flag_clr = 2'b01;
    for (int i = 0; i < 3; i++) begin
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e || tif.cnt !== 64'd0 || tif.match_flag !== 1'b1) begin
        errors++; $display("FAIL reload_cmp0[%0d] got=%h exp=%h", i, dut_out(), e);
      end
    end
    idle();
  endtask

  task automatic test_overflow();
    exp_t e;
    setup();
    for (int i = 0; i < 4; i++) begin
      tif.wr_sel   = (i == 0) ? 2'b11 : 2'b00;
      tif.pstrb    = 4'hF;
      tif.wdata    = 32'hFFFF_FFFF;
      tif.count_en = (i == 1);
      tif.flag_clr = (i == 2) ? 2'b10 : 2'b00;
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e) begin
        errors++; $display("FAIL ovf_sb[%0d] got=%h exp=%h", i, dut_out(), e);
      end
      if (i == 1) begin
        checks++;
        if (tif.cnt !== 64'd0 || tif.ovf_flag !== 1'b1) begin
          errors++; $display("FAIL ovf_wrap got=%h/%b exp=0/1",
                             tif.cnt, tif.ovf_flag);
        end
      end
      if (i == 2) begin
        checks++;
        if (tif.ovf_flag !== 1'b0) begin
          errors++; $display("FAIL ovf_clr got=%b exp=0", tif.ovf_flag);
        end
      end
    end
    idle();
  endtask

  task automatic test_halt();
    exp_t e;
    setup();
    tif.dbg_mode = 1; tif.div_en = 1; tif.div_val = 8'd2; tif.count_en = 1;
    for (int i = 0; i < 9; i++) begin
      tif.halt_req = (i >= 4 && i <= 6);
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e) begin
        errors++; $display("FAIL halt_sb[%0d] got=%h exp=%h", i, dut_out(), e);
      end
      if (i >= 4) begin
        checks++;
        if (tif.halt_ack !== (i <= 6) ||
            tif.cnt !== ((i == 8) ? 64'd2 : 64'd1)) begin
          errors++; $display("FAIL halt_hold[%0d] got=%b/%0d exp=%b/%0d", i,
            tif.halt_ack, tif.cnt, i <= 6, (i == 8) ? 2 : 1);
        end
      end
    end
    tif.halt_req = 0; tif.div_en = 0;
    for (int i = 0; i < 3; i++) begin
      advance(); e = sb.pop_front();
    end
    rst_n = 0;
    #1;
    checks++;
    if (dut_out() !== '0) begin
      errors++; $display("FAIL halt_rst got=%h exp=0", dut_out());
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    advance(); e = sb.pop_front(); checks++;
    if (dut_out() !== e || tif.cnt !== 64'd1) begin
      errors++; $display("FAIL rst_resume got=%h exp=%h", dut_out(), e);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    setup();
    tif.dbg_mode = 1;
    for (int i = 0; i < 400; i++) begin
      tif.count_en = $urandom_range(0, 9) < 8;
      tif.div_en   = 1'($urandom_range(0, 1));
      tif.div_val  = 8'($urandom_range(0, 3));
      tif.mode     = 1'($urandom_range(0, 1));
      tif.halt_req = $urandom_range(0, 9) == 0;
      tif.cmp_val  = {32'h0, 32'($urandom_range(0, 9))};
      tif.flag_clr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      tif.pstrb    = 4'($urandom_range(0, 15));
      tif.wdata    = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      tif.wr_sel   = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      advance(); e = sb.pop_front(); checks++;
      if (dut_out() !== e) begin
        errors++; $display("FAIL b2b_sb[%0d] got=%h exp=%h", i, dut_out(), e);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_count();
    test_prescaler();
    test_write();
    test_reload();
    test_overflow();
    test_halt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
